// File: rtl/logic_wordunit_seq_if.sv
// Operand/result bundle for the chunk-serial logic unit.
// Master issues start/op/operands; slave returns result and flags.
interface logic_wordunit_seq_if #(
  parameter int w = 64
);
  logic         start;
  logic [2:0]   op;
  logic [w-1:0] in_0;
  logic [w-1:0] in_1;
  logic [w-1:0] out;
  logic         busy;
  logic         done;
  logic         zero;
  logic         parity;

  modport master (
    output start,
    output op,
    output in_0,
    output in_1,
    input  out,
    input  busy,
    input  done,
    input  zero,
    input  parity
  );

  modport slave (
    input  start,
    input  op,
    input  in_0,
    input  in_1,
    output out,
    output busy,
    output done,
    output zero,
    output parity
  );
endinterface

// File: rtl/logic_wordunit_seq.sv
// Eight-op bitwise logic unit that walks a w-bit word in c-bit chunks,
// one chunk per cycle, with start/busy/done handshake and zero/parity flags.
module logic_wordunit_seq #(
  parameter int w = 64,
  parameter int c = 16
) (
  input logic             clk,
  input logic             rst_n,
  logic_wordunit_seq_if.slave bus
);

  localparam int N  = w / c;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  if (c < 1 || (w % c) != 0) begin : g_bad_cfg
    $fatal(1, "logic_wordunit_seq: w must be a multiple of c");
  end

  logic [0:0]   state;
  logic [w-1:0] a_q;
  logic [w-1:0] b_q;
  logic [2:0]   op_q;
  logic [CW-1:0] cnt;
  logic [c-1:0] or_acc;
  logic         xor_acc;

  logic [w-1:0] out_q;
  logic         busy_q;
  logic         done_q;
  logic         zero_q;
  logic         par_q;

  logic [c-1:0] a_ch;
  logic [c-1:0] b_ch;
  logic [c-1:0] res;
  logic         last;

  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        a_ch = a_q[i*c +: c];
        b_ch = b_q[i*c +: c];
      end
    end
  end

  always_comb begin
    res = '0;
    unique case (op_q)
      3'b000: res = a_ch & b_ch;
      3'b001: res = a_ch | b_ch;
      3'b010: res = a_ch ^ b_ch;
      3'b011: res = ~(a_ch ^ b_ch);
      3'b100: res = ~(a_ch & b_ch);
      3'b101: res = ~(a_ch | b_ch);
      3'b110: res = ~a_ch;
      3'b111: res = a_ch;
      default: res = '0;
    endcase
  end

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt     <= '0;
      or_acc  <= '0;
      xor_acc <= 1'b0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.in_0;
            b_q     <= bus.in_1;
            op_q    <= bus.op;
            out_q   <= '0;
            cnt     <= '0;
            or_acc  <= '0;
            xor_acc <= 1'b0;
            state   <= BUSY;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
              out_q[i*c +: c] <= res;
            end
          end
          // Flags fold in the final chunk directly; accumulators stop here.
          if (last) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            zero_q <= ~((|or_acc) | (|res));
            par_q  <= xor_acc ^ (^res);
          end else begin
            cnt     <= cnt + CW'(1);
            or_acc  <= or_acc | res;
            xor_acc <= xor_acc ^ (^res);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out    = out_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.zero   = zero_q;
  assign bus.parity = par_q;

endmodule

// File: tb/tb_logic_wordunit_seq.sv
// Bench for logic_wordunit_seq: an 8/4 and a 64/16 instance, a word-level
// reference model checked every cycle, plus directed literal checks.
module tb_logic_wordunit_seq;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic_wordunit_seq_if #(.w(8))  b0 ();
  logic_wordunit_seq_if #(.w(64)) b1 ();

  logic_wordunit_seq #(.w(8), .c(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  logic_wordunit_seq #(.w(64), .c(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cw(int d);
    return (d == 0) ? 4 : 16;
  endfunction

  function automatic int nn(int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic logic [63:0] lowm(int bits);
    if (bits >= 64) return '1;
    return (64'd1 << bits) - 64'd1;
  endfunction

  function automatic logic [63:0] opf(logic [2:0] o,
                                     logic [63:0] a,
                                     logic [63:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a ^ b);
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  // Word-level reference: whole result computed at acceptance,
  // revealed chunk by chunk from the bottom.
  logic [63:0] m_res  [2];
  logic [63:0] m_out  [2];
  logic        m_busy [2];
  logic        m_done [2];
  logic        m_zero [2];
  logic        m_par  [2];
  int          m_k    [2];

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      m_res[d]  = '0;
      m_out[d]  = '0;
      m_busy[d] = 1'b0;
      m_done[d] = 1'b0;
      m_zero[d] = 1'b0;
      m_par[d]  = 1'b0;
      m_k[d]    = 0;
    end
  endtask

  always @(negedge rst_n) mreset();

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        logic        st;
        logic [2:0]  o;
        logic [63:0] a;
        logic [63:0] b;
        st = (d == 0) ? b0.start : b1.start;
        o  = (d == 0) ? b0.op : b1.op;
        a  = (d == 0) ? 64'(b0.in_0) : b1.in_0;
        b  = (d == 0) ? 64'(b0.in_1) : b1.in_1;
        if (!m_busy[d]) begin
          m_done[d] = 1'b0;
          if (st) begin
            m_res[d]  = opf(o, a, b) & lowm(cw(d) * nn(d));
            m_out[d]  = '0;
            m_k[d]    = 0;
            m_busy[d] = 1'b1;
          end
        end else begin
          m_k[d]   = m_k[d] + 1;
          m_out[d] = m_res[d] & lowm(m_k[d] * cw(d));
          if (m_k[d] == nn(d)) begin
            m_busy[d] = 1'b0;
            m_done[d] = 1'b1;
            m_zero[d] = (m_res[d] == 64'd0);
            m_par[d]  = ^m_res[d];
          end
        end
      end
    end
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [63:0] o;
      logic [4:0]  f;
      o = (d == 0) ? 64'(b0.out) : b1.out;
      f = (d == 0)
        ? {b0.busy, b0.done, b0.zero, b0.parity, 1'b0}
        : {b1.busy, b1.done, b1.zero, b1.parity, 1'b0};
      chk($sformatf("model_out%0d", d), o, m_out[d]);
      chk($sformatf("model_flags%0d", d), 64'(f),
          64'({m_busy[d], m_done[d], m_zero[d], m_par[d], 1'b0}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(int d, logic [2:0] o,
                          logic [63:0] a, logic [63:0] b);
    @(negedge clk);
    #1;
    if (d == 0) begin
      b0.start = 1'b1;
      b0.op    = o;
      b0.in_0  = a[7:0];
      b0.in_1  = b[7:0];
    end else begin
      b1.start = 1'b1;
      b1.op    = o;
      b1.in_0  = a;
      b1.in_1  = b;
    end
    step();
    b0.start = 1'b0;
    b1.start = 1'b0;
  endtask

  logic [7:0] sweep [8];
  int n;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sweep = '{8'h42, 8'hDB, 8'h99, 8'h66, 8'hBD, 8'h24, 8'h3C, 8'hC3};
    mreset();
    rst_n    = 1'b0;
    b0.start = 1'b0; b0.op = '0; b0.in_0 = '0; b0.in_1 = '0;
    b1.start = 1'b0; b1.op = '0; b1.in_0 = '0; b1.in_1 = '0;
    #1;
    chk("rst_out0", 64'(b0.out), 0);
    chk("rst_flags0", 64'({b0.busy, b0.done, b0.zero, b0.parity}), 0);
    chk("rst_out1", b1.out, 0);
    chk("rst_flags1", 64'({b1.busy, b1.done, b1.zero, b1.parity}), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // XNOR on the 8/4 instance, chunk by chunk
    start_op(0, 3'b011, 64'hA5, 64'h0F);
    step();
    chk("xnor_e1_out", 64'(b0.out), 64'h05);
    chk("xnor_e1_busy", 64'(b0.busy), 1);
    step();
    chk("xnor_e2_out", 64'(b0.out), 64'h55);
    chk("xnor_e2_flags",
        64'({b0.done, b0.busy, b0.zero, b0.parity}), 64'b1000);
    step();
    chk("xnor_done_pulse", 64'(b0.done), 0);

    // XOR of equal words: zero result, busy exactly four cycles
    start_op(1, 3'b010, 64'hDEADBEEF01234567, 64'hDEADBEEF01234567);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!b1.busy) break;
      n++;
      step();
    end
    chk("xor_busy_cycles", 64'(n), 4);
    chk("xor_out", b1.out, 0);
    chk("xor_flags", 64'({b1.done, b1.zero, b1.parity}), 64'b110);
    step();
    chk("xor_done_pulse", 64'(b1.done), 0);

    // asynchronous reset mid-cycle with random inputs
    @(negedge clk);
    #1;
    b0.start = 1'($urandom); b0.op = 3'($urandom);
    b0.in_0 = 8'($urandom); b0.in_1 = 8'($urandom);
    b1.start = 1'($urandom); b1.op = 3'($urandom);
    b1.in_0 = {$urandom, $urandom}; b1.in_1 = {$urandom, $urandom};
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out1", b1.out, 0);
    chk("arst_flags1", 64'({b1.busy, b1.done, b1.zero, b1.parity}), 0);
    chk("arst_flags0", 64'({b0.busy, b0.done, b0.zero, b0.parity}), 0);
    b0.start = 1'b0;
    b1.start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // operands and op latched; start while busy ignored
    start_op(1, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    b1.in_1  = 64'h0;
    b1.op    = 3'b101;
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    n = 0;
    while (!b1.done && n < 8) begin
      step();
      n++;
    end
    chk("and_done_seen", 64'(b1.done), 1);
    chk("and_out", b1.out, 64'h1);
    chk("and_flags", 64'({b1.zero, b1.parity}), 64'b01);
    // back-to-back start inside the done cycle
    b1.start = 1'b1;
    b1.op    = 3'b110;
    b1.in_0  = 64'h0;
    step();
    b1.start = 1'b0;
    chk("b2b_accept", 64'({b1.busy, b1.done}), 64'b10);
    chk("b2b_out_clear", b1.out, 0);
    chk("b2b_flags_held", 64'({b1.zero, b1.parity}), 64'b01);
    repeat (4) step();
    chk("not_out", b1.out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("not_flags", 64'({b1.done, b1.zero, b1.parity}), 64'b100);

    // reset after two chunks aborts, then a normal NOR run
    start_op(1, 3'b001, 64'h1234, 64'h5678);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out", b1.out, 0);
    chk("abort_flags", 64'({b1.busy, b1.done, b1.zero, b1.parity}), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    chk("abort_no_done", 64'(b1.done), 0);
    start_op(1, 3'b101, 64'h0, 64'h0);
    repeat (4) step();
    chk("nor_out", b1.out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("nor_flags", 64'({b1.done, b1.zero, b1.parity}), 64'b100);

    // op sweep on the 8/4 instance
    for (int o = 0; o < 8; o++) begin
      chk($sformatf("model_op%0d", o),
          opf(3'(o), 64'hC3, 64'h5A) & 64'hFF, 64'(sweep[o]));
      start_op(0, 3'(o), 64'hC3, 64'h5A);
      step();
      step();
      chk($sformatf("sweep_out%0d", o), 64'(b0.out), 64'(sweep[o]));
      chk($sformatf("sweep_flags%0d", o),
          64'({b0.done, b0.zero, b0.parity}), 64'b100);
    end

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
